pid_loop_sequencer: RTL and testbench

//  Periodic scheduler for the PID datapath behind the APB register block.
//  - Samples the APB-written setpoint (target), measurement (y) and gain set (para) on a programmable tick.
//  - Hands the sample to the PID core over a req/ack handshake and registers the result as the actuator word.
//  - Flags overruns and PID-core timeouts.

---
 rtl/pid_loop_sequencer_if.sv | 37 +++
 rtl/pid_loop_sequencer.sv | 129 ++++++++++++
 tb/tb_pid_loop_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pid_loop_sequencer_if.sv
// Handshake/register bundle between the APB register block, the PID core and
// pid_loop_sequencer. The sequencer takes the slave view, the surroundings the master view.
interface pid_loop_sequencer_if #(
  parameter int CNT_W = 16,
  parameter int DW    = 12,
  parameter int RW    = 17
);
  logic             enable;
  logic [CNT_W-1:0] period;
  logic [DW-1:0]    target;
  logic [DW-1:0]    y;
  logic [DW-1:0]    para;
  logic             err_clr;
  logic             pid_req;
  logic [DW-1:0]    pid_target;
  logic [DW-1:0]    pid_y;
  logic [DW-1:0]    pid_para;
  logic             pid_ack;
  logic [RW-1:0]    pid_result;
  logic [DW-1:0]    ctrl_out;
  logic             ctrl_valid;
  logic             busy;
  logic             overrun;
  logic             timeout_err;

  modport slave (
    input  enable, period, target, y, para, err_clr, pid_ack, pid_result,
    output pid_req, pid_target, pid_y, pid_para, ctrl_out, ctrl_valid, busy,
           overrun, timeout_err
  );

  modport master (
    output enable, period, target, y, para, err_clr, pid_ack, pid_result,
    input  pid_req, pid_target, pid_y, pid_para, ctrl_out, ctrl_valid, busy,
           overrun, timeout_err
  );
endinterface

// File: rtl/pid_loop_sequencer.sv
// Periodic sampler/scheduler that feeds the PID core over req/ack and registers its result.
// Define PID_SAT_EN to saturate the result to DW bits instead of truncating it.
module pid_loop_sequencer #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64,
  parameter int DW      = 12,
  parameter int RW      = 17
) (
  input logic                 PCLK,
  input logic                 PRESET,
  pid_loop_sequencer_if.slave bus
);
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [DW-1:0]    target_q, target_d, y_q, y_d, para_q, para_d;
  logic [DW-1:0]    ctrl_out_q, ctrl_out_d;
  logic             overrun_q, overrun_d, timeout_q, timeout_d;
  logic             tick, timeout_set;
  logic [DW-1:0]    result_conv;

`ifdef PID_SAT_EN
  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};
  logic [RW-DW:0] res_hi;
  assign res_hi = bus.pid_result[RW-1:DW-1];
  // Result fits DW bits only when every bit above the new sign bit matches it.
  always_comb begin
    result_conv = bus.pid_result[DW-1:0];
    if (res_hi != '0 && res_hi != '1) begin
      result_conv = bus.pid_result[RW-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  logic unused_res_hi;
  assign result_conv   = bus.pid_result[DW-1:0];
  assign unused_res_hi = ^bus.pid_result[RW-1:DW];
`endif

  // Compare with >= so a period shortened below the running count still wraps.
  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    tick  = 1'b0;
    cnt_d = '0;
    if (bus.enable && bus.period != '0) begin
      if (cnt_q >= bus.period - CNT_W'(1)) tick = 1'b1;
      else cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    target_d    = target_q;
    y_d         = y_q;
    para_d      = para_q;
    ctrl_out_d  = ctrl_out_q;
    timeout_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          target_d = bus.target;
          y_d      = bus.y;
          para_d   = bus.para;
          wd_d     = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        // Ack is checked before the watchdog so a last-cycle ack still completes.
        if (bus.pid_ack) begin
          ctrl_out_d = result_conv;
          state_d    = DONE;
        end else if (wd_q == WD_LAST) begin
          timeout_set = 1'b1;
          state_d     = IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign overrun_d = (overrun_q & ~bus.err_clr) | (tick & (state_q != IDLE));
  assign timeout_d = (timeout_q & ~bus.err_clr) | timeout_set;

  // NOTE: state is updated with non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wd_q       <= '0;
      target_q   <= '0;
      y_q        <= '0;
      para_q     <= '0;
      ctrl_out_q <= '0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wd_q       <= wd_d;
      target_q   <= target_d;
      y_q        <= y_d;
      para_q     <= para_d;
      ctrl_out_q <= ctrl_out_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.pid_req     = (state_q == REQ);
  assign bus.ctrl_valid  = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.pid_target  = target_q;
  assign bus.pid_y       = y_q;
  assign bus.pid_para    = para_q;
  assign bus.ctrl_out    = ctrl_out_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Self-checking bench for pid_loop_sequencer: cycle model of the scheduling rules plus
// directed scenarios with hand-computed expectations.
module tb_pid_loop_sequencer;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 64;
  localparam int DW      = 12;
  localparam int RW      = 17;

  logic PCLK = 1'b0;
  logic PRESET;
  always #5 PCLK = ~PCLK;

  pid_loop_sequencer_if #(.CNT_W(CNT_W), .DW(DW), .RW(RW)) bus ();

  pid_loop_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .DW(DW), .RW(RW)) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit cmp_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge PCLK) cyc++;

  // Expected actuator word from the signed value of the result.
  function automatic logic [DW-1:0] exp_conv(input logic [RW-1:0] r);
    int v;
    v = $signed(r);
`ifdef PID_SAT_EN
    if (v > 2047) return 12'h7FF;
    if (v < -2048) return 12'h800;
`endif
    return r[DW-1:0];
  endfunction

  // ---------------- cycle model ----------------
  bit             m_req, m_valid, m_ovr, m_tmo;
  int             m_high, m_phase;
  logic [DW-1:0]  m_ctrl, m_tgt, m_y, m_para;

  initial begin
    m_req = 0; m_valid = 0; m_ovr = 0; m_tmo = 0; m_high = 0; m_phase = 0;
    m_ctrl = '0; m_tgt = '0; m_y = '0; m_para = '0;
  end

  always @(posedge PCLK) begin
    bit per_on, tick, ovr_set, tmo_set, finished;
    per_on = bus.enable && bus.period != 0;
    tick   = per_on && (m_phase + 1 >= int'(bus.period));
    if (PRESET) begin
      m_req = 0; m_valid = 0; m_ovr = 0; m_tmo = 0; m_high = 0; m_phase = 0;
      m_ctrl = '0; m_tgt = '0; m_y = '0; m_para = '0;
    end else begin
      m_phase  = (per_on && !tick) ? m_phase + 1 : 0;
      ovr_set  = tick && (m_req || m_valid);
      tmo_set  = 0;
      finished = 0;
      if (m_req) begin
        if (bus.pid_ack) begin
          m_ctrl   = exp_conv(bus.pid_result);
          finished = 1;
          m_req    = 0;
        end else if (m_high + 1 == TIMEOUT) begin
          tmo_set = 1;
          m_req   = 0;
        end else begin
          m_high++;
        end
      end else if (!m_valid && tick) begin
        m_tgt = bus.target; m_y = bus.y; m_para = bus.para;
        m_req = 1; m_high = 0;
      end
      m_valid = finished;
      m_ovr   = (m_ovr && !bus.err_clr) || ovr_set;
      m_tmo   = (m_tmo && !bus.err_clr) || tmo_set;
    end
  end

  // ---------------- compare + event monitor ----------------
  int req_rise[$];
  int valid_cnt = 0;
  int run_len   = 0;
  int last_run  = 0;
  bit prev_req  = 0;

  always @(negedge PCLK) begin
    if (cmp_on) begin
      check("pid_req",     bus.pid_req,     m_req);
      check("busy",        bus.busy,        m_req || m_valid);
      check("ctrl_valid",  bus.ctrl_valid,  m_valid);
      check("ctrl_out",    bus.ctrl_out,    m_ctrl);
      check("overrun",     bus.overrun,     m_ovr);
      check("timeout_err", bus.timeout_err, m_tmo);
      check("pid_target",  bus.pid_target,  m_tgt);
      check("pid_y",       bus.pid_y,       m_y);
      check("pid_para",    bus.pid_para,    m_para);
      if (bus.pid_req === 1'b1 && !prev_req) req_rise.push_back(cyc);
      if (bus.pid_req !== 1'b1 && prev_req) begin
        last_run = run_len;
        run_len  = 0;
      end
      if (bus.pid_req === 1'b1) run_len++;
      if (bus.ctrl_valid === 1'b1) valid_cnt++;
      prev_req = (bus.pid_req === 1'b1);
    end
  end

  // ---------------- PID core responder ----------------
  int ack_delay = -1;
  bit ack_force = 0;
  int req_cycles = 0;

  always @(posedge PCLK) begin
    #1;
    if (bus.pid_req === 1'b1) begin
      bus.pid_ack = ack_force || (ack_delay >= 0 && req_cycles == ack_delay);
      req_cycles++;
    end else begin
      bus.pid_ack = ack_force;
      req_cycles  = 0;
    end
  end

  // ---------------- helpers ----------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic wait_rises(input int n, input int budget);
    int k = 0;
    while (req_rise.size() < n && k < budget) begin cycles(1); k++; end
    check("wait_pid_req_rise", req_rise.size() >= n, 1);
  endtask

  task automatic wait_valids(input int n, input int budget);
    int k = 0;
    while (valid_cnt < n && k < budget) begin cycles(1); k++; end
    check("wait_ctrl_valid", valid_cnt >= n, 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (bus.busy !== 1'b0 && k < budget) begin cycles(1); k++; end
    cycles(1);
    check("wait_idle", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int r0, v0;
    PRESET = 1'b1;
    bus.enable = 1'($urandom); bus.period = 16'($urandom);
    bus.target = 12'($urandom); bus.y = 12'($urandom); bus.para = 12'($urandom);
    bus.err_clr = 1'($urandom); bus.pid_ack = 1'b0; bus.pid_result = 17'($urandom);

    // 1: reset with random inputs
    cycles(1);
    cmp_on = 1'b1;
    cycles(1);
    check("rst_pid_req", bus.pid_req, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ctrl_out", bus.ctrl_out, 0);
    check("rst_ctrl_valid", bus.ctrl_valid, 0);
    check("rst_flags", {bus.overrun, bus.timeout_err}, 0);
    check("rst_pid_target", bus.pid_target, 0);

    // 2: basic transaction, period 10, ack 3 cycles after request
    PRESET = 1'b0; bus.err_clr = 1'b0;
    bus.period = 16'd10; bus.enable = 1'b1;
    bus.target = 12'h100; bus.y = 12'h080; bus.para = 12'h00A;
    bus.pid_result = 17'h00123; ack_delay = 3;
    r0 = req_rise.size(); v0 = valid_cnt;
    wait_rises(r0 + 1, 40);
    check("s2_pid_target", bus.pid_target, 12'h100);
    check("s2_pid_y", bus.pid_y, 12'h080);
    wait_valids(v0 + 1, 20);
    check("s2_ctrl_out", bus.ctrl_out, 12'h123);
    wait_rises(r0 + 2, 40);
    if (req_rise.size() >= r0 + 2) check("s2_tick_spacing", req_rise[r0 + 1] - req_rise[r0], 10);
    check("s2_single_valid", valid_cnt - v0, 1);
    bus.enable = 1'b0;
    wait_idle(20);

    // 3: period 4 with slow ack -> overruns, one request per transaction
    bus.period = 16'd4; bus.pid_result = 17'h00456; ack_delay = 6;
    r0 = req_rise.size(); v0 = valid_cnt;
    bus.enable = 1'b1;
    cycles(40);
    bus.enable = 1'b0;
    wait_idle(20);
    check("s3_overrun", bus.overrun, 1);
    check("s3_req_per_txn", req_rise.size() - r0, valid_cnt - v0);
    check("s3_ctrl_out", bus.ctrl_out, 12'h456);
    bus.err_clr = 1'b1;
    cycles(1);
    bus.err_clr = 1'b0;
    check("s3_overrun_clr", bus.overrun, 0);
    // err_clr held through overrunning ticks: set must win in the colliding cycle
    bus.err_clr = 1'b1; bus.enable = 1'b1;
    cycles(30);
    bus.enable = 1'b0;
    wait_idle(20);
    bus.err_clr = 1'b0;
    cycles(2);

    // 4: PID core never acks -> watchdog abort after TIMEOUT cycles
    check("s4_tmo_before", bus.timeout_err, 0);
    bus.period = 16'd200; ack_delay = -1;
    r0 = req_rise.size();
    bus.enable = 1'b1;
    wait_rises(r0 + 1, 250);
    begin
      int k = 0;
      while (bus.pid_req === 1'b1 && k < 100) begin cycles(1); k++; end
    end
    bus.enable = 1'b0;
    check("s4_timeout_err", bus.timeout_err, 1);
    check("s4_ctrl_hold", bus.ctrl_out, 12'h456);
    cycles(1);
    check("s4_req_high_cycles", last_run, TIMEOUT);
    wait_idle(10);

    // 5: result width conversion
    bus.period = 16'd5; ack_delay = 0; bus.pid_result = 17'h01000;
    v0 = valid_cnt;
    bus.enable = 1'b1;
    wait_valids(v0 + 1, 20);
`ifdef PID_SAT_EN
    check("s5_pos_over", bus.ctrl_out, 12'h7FF);
`else
    check("s5_pos_over", bus.ctrl_out, 12'h000);
`endif
    bus.pid_result = 17'h1F000;
    wait_valids(v0 + 2, 20);
`ifdef PID_SAT_EN
    check("s5_neg_over", bus.ctrl_out, 12'h800);
`else
    check("s5_neg_over", bus.ctrl_out, 12'h000);
`endif
    bus.pid_result = 17'h1FF80;
    wait_valids(v0 + 3, 20);
    check("s5_neg_in_range", bus.ctrl_out, 12'hF80);
    bus.enable = 1'b0;
    wait_idle(20);

    // 6: reset while a request is outstanding; a later ack must be ignored
    ack_delay = -1;
    r0 = req_rise.size();
    bus.enable = 1'b1;
    wait_rises(r0 + 1, 20);
    cycles(2);
    check("s6_req_before", bus.pid_req, 1);
    PRESET = 1'b1;
    cycles(1);
    PRESET = 1'b0; bus.enable = 1'b0;
    check("s6_pid_req", bus.pid_req, 0);
    check("s6_busy", bus.busy, 0);
    check("s6_flags", {bus.overrun, bus.timeout_err}, 0);
    check("s6_ctrl_out", bus.ctrl_out, 0);
    v0 = valid_cnt;
    ack_force = 1'b1;
    cycles(5);
    ack_force = 1'b0;
    cycles(2);
    check("s6_ack_ignored", valid_cnt - v0, 0);
    check("s6_still_idle", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
